// File: rtl/prog_ram.sv
// Program memory behind the PC address bus, with a byte-serial load path and
// a pc_recount pulse that sends the PC counter back to address 0.
module prog_ram #(
    parameter int              ADDR_W  = 8,
    parameter int              DATA_W  = 8,
    parameter int              DEPTH   = 256,
    parameter logic [DATA_W-1:0] HALT_OP = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              fetch_en,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              prog_mode,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              load_full,
    output logic              pc_recount
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        EXIT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] rd_byte;
    logic              wr_hs;
    logic              mem_we;

    assign rd_byte = mem[pc_addr];
    assign wr_hs   = wr_valid && wr_ready;
    // A reset in the same cycle as a handshake wins, so that byte is dropped.
    assign mem_we  = (state == LOAD) && wr_hs && !reset;

    // Storage is never cleared, so a reset keeps whatever was loaded.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            instr       <= '0;
            instr_valid <= 1'b0;
            wr_ready    <= 1'b0;
            load_count  <= '0;
            load_full   <= 1'b0;
            pc_recount  <= 1'b0;
            wr_ptr      <= '0;
        end else begin
            case (state)
                RUN: begin
                    wr_ready   <= 1'b0;
                    pc_recount <= 1'b0;
                    if (prog_mode) begin
                        state       <= LOAD;
                        instr_valid <= 1'b0;
                        wr_ptr      <= '0;
                        load_count  <= '0;
                        load_full   <= 1'b0;
                        wr_ready    <= 1'b1;
                    end else if (fetch_en) begin
                        instr       <= rd_byte;
                        instr_valid <= 1'b1;
                        pc_recount  <= (rd_byte == HALT_OP);
                    end else begin
                        instr_valid <= 1'b0;
                    end
                end

                LOAD: begin
                    instr_valid <= 1'b0;
                    pc_recount  <= 1'b0;
                    if (wr_hs) begin
                        load_count <= load_count + CNT_ONE;
                        // The pointer parks on the last word instead of wrapping.
                        if (wr_ptr == LAST_ADDR) begin
                            load_full <= 1'b1;
                            wr_ready  <= 1'b0;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                        end
                    end
                    if (!prog_mode) begin
                        state      <= EXIT;
                        wr_ready   <= 1'b0;
                        pc_recount <= 1'b1;
                    end
                end

                EXIT: begin
                    state       <= RUN;
                    instr_valid <= 1'b0;
                    wr_ready    <= 1'b0;
                    pc_recount  <= 1'b0;
                end

                default: begin
                    state       <= RUN;
                    instr_valid <= 1'b0;
                    wr_ready    <= 1'b0;
                    pc_recount  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ram.sv
// Scoreboard bench for prog_ram: load sessions, fetches, HALT pulses,
// full-load limit, exit race and reset during load.
module tb_prog_ram;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pc_addr;
    logic       fetch_en;
    logic [7:0] instr;
    logic       instr_valid;
    logic       prog_mode;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [8:0] load_count;
    logic       load_full;
    logic       pc_recount;

    always #5 clk = ~clk;

    prog_ram dut (
        .clk         (clk),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .fetch_en    (fetch_en),
        .instr       (instr),
        .instr_valid (instr_valid),
        .prog_mode   (prog_mode),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .load_count  (load_count),
        .load_full   (load_full),
        .pc_recount  (pc_recount)
    );

    typedef struct {
        logic [7:0] d;
        logic       h;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model[256];
    logic [7:0] wbuf[$];
    logic [7:0] abuf[$];
    int         checks   = 0;
    int         failures = 0;
    int         mptr;
    bit         mon_en   = 1'b0;
    bit         exp_vld;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        exp_vld = fetch_en && !prog_mode && !reset;
        @(posedge clk);
        #1;
        if (mon_en) begin
            chk("instr_valid", instr_valid, exp_vld);
            if (instr_valid === 1'b1) begin
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("instr", instr, e.d);
                    chk("halt_recount", pc_recount, e.h);
                end
            end
        end
    endtask

    task automatic fetch_seq();
        exp_t e;
        foreach (abuf[i]) begin
            fetch_en = 1'b1;
            pc_addr  = abuf[i];
            e.d = model[abuf[i]];
            e.h = (model[abuf[i]] == 8'hFF);
            sb_q.push_back(e);
            step();
        end
        fetch_en = 1'b0;
        step();
        chk("recount_idle", pc_recount, 0);
        chk("sb_drained", sb_q.size(), 0);
    endtask

    task automatic do_load(input int n, input bit gaps, input bit race);
        int acc   = 0;
        int guard = 0;
        fetch_en  = 1'b0;
        wr_valid  = 1'b0;
        prog_mode = 1'b1;
        step();
        mptr = 0;
        chk("ld_entry_ready", wr_ready, 1);
        chk("ld_entry_count", load_count, 0);
        while (acc < n && guard < 1000) begin
            guard++;
            wr_valid = !gaps || ($urandom_range(0, 2) != 0);
            wr_data  = wbuf[acc];
            if (race && acc == n - 1) begin
                wr_valid  = 1'b1;
                prog_mode = 1'b0;
            end
            step();
            if (wr_valid) begin
                model[mptr[7:0]] = wbuf[acc];
                mptr++;
                acc++;
            end
            if (prog_mode) chk("ld_ready", wr_ready, mptr < 256);
        end
        chk("ld_timeout", acc, n);
        wr_valid = 1'b0;
        if (!race) begin
            prog_mode = 1'b0;
            step();
        end
        chk("exit_recount", pc_recount, 1);
        chk("exit_ready", wr_ready, 0);
        chk("exit_count", load_count, n);
        step();
        chk("run_recount", pc_recount, 0);
        chk("run_ready", wr_ready, 0);
    endtask

    initial begin
        int acc;
        bit hs_exp;
        logic [7:0] b;
        reset     = 1'b1;
        pc_addr   = '0;
        fetch_en  = 1'b0;
        prog_mode = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        step();
        step();
        chk("rst_instr", instr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_ready", wr_ready, 0);
        chk("rst_count", load_count, 0);
        chk("rst_full", load_full, 0);
        chk("rst_recount", pc_recount, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Basic load then back-to-back fetch
        wbuf = '{8'h11, 8'h22, 8'h33};
        do_load(3, 1'b0, 1'b0);
        abuf = '{8'd0, 8'd1, 8'd2};
        fetch_seq();

        // HALT opcode fetch
        wbuf = '{8'h05, 8'hFF};
        do_load(2, 1'b0, 1'b0);
        abuf = '{8'd0, 8'd1, 8'd0};
        fetch_seq();

        // Zero-byte session still pulses pc_recount
        do_load(0, 1'b0, 1'b0);

        // Full load with 300 offered bytes
        prog_mode = 1'b1;
        step();
        mptr = 0;
        acc  = 0;
        for (int c = 0; c < 300; c++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(c) ^ 8'h5A;
            hs_exp   = (acc < 256);
            step();
            if (hs_exp) begin
                model[acc] = wr_data;
                acc++;
            end
            chk("full_ready", wr_ready, acc < 256);
        end
        chk("full_count", load_count, 256);
        chk("full_flag", load_full, 1);
        wr_valid  = 1'b0;
        prog_mode = 1'b0;
        step();
        chk("full_exit_recount", pc_recount, 1);
        step();
        chk("full_hold_flag", load_full, 1);
        chk("full_hold_count", load_count, 256);
        abuf = '{8'd255, 8'd0, 8'd254};
        fetch_seq();

        // Writes offered in RUN are ignored
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        step();
        chk("run_wr_ready", wr_ready, 0);
        wr_valid = 1'b0;
        abuf = '{8'd0};
        fetch_seq();

        // Random gaps, prog_mode dropped on the A5 handshake
        wbuf.delete();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 254));
            wbuf.push_back(b);
        end
        wbuf.push_back(8'hA5);
        do_load(7, 1'b1, 1'b1);
        abuf = '{8'd6, 8'd0, 8'd3, 8'd5, 8'd7};
        fetch_seq();

        // Reset in the middle of a load session
        prog_mode = 1'b1;
        step();
        mptr = 0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hC0 + 8'(i);
            step();
            model[i] = 8'hC0 + 8'(i);
        end
        chk("mid_count", load_count, 4);
        wr_valid = 1'b0;
        reset    = 1'b1;
        step();
        chk("mid_rst_ready", wr_ready, 0);
        chk("mid_rst_count", load_count, 0);
        chk("mid_rst_full", load_full, 0);
        chk("mid_rst_recount", pc_recount, 0);
        reset = 1'b0;
        step();
        chk("mid_reentry_recount", pc_recount, 0);
        chk("mid_reentry_ready", wr_ready, 1);
        chk("mid_reentry_count", load_count, 0);
        prog_mode = 1'b0;
        step();
        chk("mid_exit_recount", pc_recount, 1);
        step();
        abuf = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        fetch_seq();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_ram.md
Name: prog_ram

Overview:
- Program memory at the far end of the PC address bus: accepts the 8-bit PC address and returns the instruction byte one cycle later.
- Also hosts the program-load (擦写) path: a byte-serial valid/ready write port fills memory from address 0 while prog_mode is high.
- Drives pc_recount back to the PC counter on a HALT opcode fetch and on exit from load mode, so the PC restarts at 0.

Parameters:
- ADDR_W, 8, address width, matching the PC width.
- DATA_W, 8, instruction / write-data width.
- DEPTH, 256, number of words; must equal 2**ADDR_W.
- HALT_OP, 8'hFF, opcode that triggers a pc_recount pulse when fetched.

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  synchronous, active-high reset
- pc_addr  in  ADDR_W  fetch address from the PC counter
- fetch_en  in  1  fetch request, sampled each cycle in RUN
- instr  out  DATA_W  registered instruction byte
- instr_valid  out  1  instr holds data for the address sampled in the previous cycle
- prog_mode  in  1  level; high requests load mode
- wr_valid  in  1  write-data valid
- wr_data  in  DATA_W  byte to program
- wr_ready  out  1  block accepts wr_data this cycle
- load_count  out  ADDR_W+1  bytes written in the current load session
- load_full  out  1  DEPTH bytes written, no further writes accepted
- pc_recount  out  1  one-cycle pulse to the PC counter: restart at address 0

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk. Reset is synchronous, active-high, and highest priority.
  - Reset values: state=RUN, instr=0, instr_valid=0, wr_ready=0, load_count=0, load_full=0, pc_recount=0, write pointer=0.
  - Memory contents are not cleared by reset.
- States: RUN, LOAD, EXIT.
- RUN:
  - If fetch_en=1, mem[pc_addr] is registered into instr and instr_valid=1 next cycle. Latency is exactly 1 cycle, one fetch per cycle, back-to-back fetches allowed.
  - If fetch_en=0, instr_valid=0 next cycle and instr holds its last value.
  - If the registered byte equals HALT_OP, pc_recount=1 in the same cycle as instr_valid=1, for that cycle only.
  - If prog_mode=1, move to LOAD next cycle. Write pointer=0, load_count=0, load_full=0. A fetch requested in that same cycle is ignored (instr_valid=0).
- LOAD:
  - instr_valid=0; fetch_en and pc_addr are ignored.
  - wr_ready=1 while load_full=0.
  - On wr_valid and wr_ready: mem[ptr]=wr_data, ptr+1, load_count+1.
  - After the DEPTH-th write: load_full=1 and wr_ready=0; ptr does not wrap, and later wr_valid is ignored.
  - If prog_mode=0, move to EXIT. A handshake in that same cycle is still committed.
- EXIT (one cycle):
  - wr_ready=0, pc_recount=1, instr_valid=0.
  - Next state is always RUN.
  - load_count and load_full hold until the next LOAD entry.
- pc_recount only ever appears as a single-cycle pulse. HALT and EXIT pulses are mutually exclusive by state.
- Arithmetic:
  - ptr is ADDR_W bits.
  - load_count is ADDR_W+1 bits so that a full load reads exactly DEPTH (256).
- Boundary cases:
  - Fetch at pc_addr=8'hFF is legal. Address wrap is the PC counter's concern.
  - prog_mode held high for 1 cycle: RUN→LOAD→EXIT→RUN with zero bytes written; pc_recount still pulses.
  - Reset during LOAD or EXIT: next cycle RUN, no pc_recount pulse, bytes already written are retained.
  - wr_valid asserted while in RUN is ignored, and wr_ready=0.

Test Plan:
- Reset then load: reset 2 cycles, prog_mode=1, write 8'h11,8'h22,8'h33 back-to-back, prog_mode=0 → load_count=3, pc_recount pulses exactly 1 cycle in EXIT, state returns to RUN.
- Fetch: fetch_en=1 with pc_addr=0,1,2 on consecutive cycles → instr=11,22,33 with instr_valid=1 one cycle after each address, no gaps.
- HALT: load 8'h05,8'hFF, then fetch addr 0,1 → instr=05 with pc_recount=0, then instr=FF with pc_recount=1 for exactly that cycle.
- Full load: 300 wr_valid cycles in LOAD → exactly 256 accepted, load_count=256, load_full=1, wr_ready=0 from cycle 257; fetch addr 255 afterward returns the 256th byte.
- Back-pressure and exit race: gap wr_valid randomly, and drop prog_mode in the same cycle as a handshake with byte 8'hA5 → byte committed at its pointer, read back as A5.
- Reset mid-load: write 4 bytes, assert reset 1 cycle with prog_mode still high → outputs at reset values, no pc_recount pulse, LOAD re-entered next cycle with load_count=0; the 4 old bytes remain readable after a clean exit.
